// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle,
// shift-add multiply and restoring divide on operand magnitudes, with
// sign correction applied on the final cycle before HI/LO are written.
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_hi_reg;   // partial product high half / remainder
    logic [WIDTH-1:0] acc_lo_reg;   // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] b_reg;        // multiplicand / divisor magnitude
    logic             is_div_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             b_zero_reg;

    // Request decode: ops 000..011 are arithmetic, 100/101 are moves.
    logic             req_arith, req_mthi, req_mtlo;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign req_arith = start && !op[2];
    assign req_mthi  = start && (op == 3'b100);
    assign req_mtlo  = start && (op == 3'b101);
    assign neg_a     = op[0] && op_a[WIDTH-1];
    assign neg_b     = op[0] && op_b[WIDTH-1];
    assign mag_a     = neg_a ? -op_a : op_a;
    assign mag_b     = neg_b ? -op_b : op_b;

    // One iteration of each algorithm, evaluated every CALC cycle.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, b_reg} : '0);
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, b_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - b_reg;

    // Sign-corrected results written in FIN.
    logic [2*WIDTH-1:0] prod_raw, prod_res;
    logic [WIDTH-1:0]   quot_res, rem_res;

    assign prod_raw = {acc_hi_reg, acc_lo_reg};
    assign prod_res = (sign_a_reg ^ sign_b_reg) ? -prod_raw : prod_raw;
    assign quot_res = (sign_a_reg ^ sign_b_reg) ? -acc_lo_reg : acc_lo_reg;
    assign rem_res  = sign_a_reg ? -acc_hi_reg : acc_hi_reg;

    assign busy = (state_reg != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: cancel only matters once an operation is in flight.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_arith) state_next = CALC;
            CALC: begin
                if (cancel)                      state_next = IDLE;
                else if (count_reg == LAST_STEP) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration steps, HI/LO and done updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            b_reg       <= '0;
            is_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            b_zero_reg  <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_arith) begin
                        count_reg  <= '0;
                        acc_hi_reg <= '0;
                        is_div_reg <= op[1];
                        sign_a_reg <= neg_a;
                        sign_b_reg <= neg_b;
                        b_zero_reg <= (op_b == '0);
                        // Divide shifts the dividend through acc_lo; multiply
                        // shifts the multiplier (rt) through it instead.
                        acc_lo_reg <= op[1] ? mag_a : mag_b;
                        b_reg      <= op[1] ? mag_b : mag_a;
                    end else if (req_mthi) begin
                        hi <= op_a;
                    end else if (req_mtlo) begin
                        lo <= op_a;
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        count_reg <= count_reg + CW'(1);
                        if (is_div_reg) begin
                            acc_hi_reg <= div_fits ? div_diff : div_shift[WIDTH-1:0];
                            acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_fits};
                        end else begin
                            acc_hi_reg <= mul_sum[WIDTH:1];
                            acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                        end
                    end
                end
                FIN: begin
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div_reg) begin
                            // Zero divisor: quotient forced to all ones; the
                            // restoring loop already leaves |op_a| as remainder,
                            // so sign correction restores op_a in HI.
                            lo          <= b_zero_reg ? '1 : quot_res;
                            hi          <= rem_res;
                            div_by_zero <= b_zero_reg;
                        end else begin
                            {hi, lo} <= prod_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Randomized and directed bench for mips_cpu_muldiv (WIDTH = 32) checked
// against a plain-arithmetic reference model of MIPS HI/LO semantics.
module tb_mips_cpu_muldiv;

    localparam int W = 32;
    localparam logic [2:0] OP_MULTU = 3'b000, OP_MULT = 3'b001, OP_DIVU = 3'b010,
                           OP_DIV = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    logic          clk, reset, start, cancel;
    logic [2:0]    op;
    logic [W-1:0]  op_a, op_b;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int tests_run = 0;
    int tests_failed = 0;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a),
        .op_b(op_b), .cancel(cancel), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: MIPS HI/LO results from ordinary arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, b,
                                  output logic [31:0] eh, el, output logic ed);
        logic [63:0] p;
        longint sa, sb;
        int qa, qb;
        p = '0; ed = 1'b0; eh = '0; el = '0;
        case (o)
            OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
            OP_MULT: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = sa * sb; eh = p[63:32]; el = p[31:0];
            end
            OP_DIVU: begin
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; ed = 1'b1; end
                else begin el = a / b; eh = a % b; end
            end
            OP_DIV: begin
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; ed = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'h0;
                end else begin
                    qa = $signed(a); qb = $signed(b);
                    el = 32'(qa / qb); eh = 32'(qa % qb);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one request for exactly one edge; returns at the following negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, b, input logic c);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b; cancel = c;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
    endtask

    // Issue an operation and observe it until done (bounded): latency in
    // edges after the start edge (0 = never), busy and HI/LO hold behaviour.
    task automatic exec_op(input logic [2:0] o, input logic [31:0] a, b, input logic c,
                           output int lat, output logic busy_ok, output logic hold_ok);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        issue(o, a, b, c);
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int k = 1; k <= W + 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) lat = k;
            else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = OP_MTHI; op_a = 32'hDEAD_BEEF; op_b = '0; cancel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; reset = 1'b1;
        $display("[TB] reset checked");
    endtask

    task automatic test_multiply();
        logic [2:0] d_op [4];
        logic [31:0] d_a [4], d_b [4];
        logic [2:0] o; logic [31:0] a, b, eh, el; logic ed, bok, hok; int lat;
        d_op = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULTU};
        d_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0};
        d_b  = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'h1234_5678};
        for (int i = 0; i < 40; i++) begin
            if (i < 4) begin o = d_op[i]; a = d_a[i]; b = d_b[i]; end
            else begin o = 3'($urandom_range(0, 1)); a = rand_val(); b = rand_val(); end
            model(o, a, b, eh, el, ed);
            exec_op(o, a, b, 1'b0, lat, bok, hok);
            $display("[TB] mul op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, a, b, hi, lo, lat);
            tests_run++; if (lat != W + 1) begin tests_failed++; $display("FAIL mul_latency: got %0d expected %0d", lat, W + 1); end
            tests_run++; if (!(bok && hok)) begin tests_failed++; $display("FAIL mul_busy_hold: got busy_ok=%b hold_ok=%b expected 1 1", bok, hok); end
            tests_run++;
            if ({hi, lo, div_by_zero, busy} !== {eh, el, ed, 1'b0}) begin
                tests_failed++;
                $display("FAIL mul_result: got hi=%h lo=%h dbz=%b busy=%b expected hi=%h lo=%h dbz=%b busy=0",
                         hi, lo, div_by_zero, busy, eh, el, ed);
            end
            @(posedge clk); #1;
            tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mul_done_pulse: got done=%b expected 0", done); end
        end
    endtask

    task automatic test_divide();
        logic [2:0] d_op [5];
        logic [31:0] d_a [5], d_b [5];
        logic [2:0] o; logic [31:0] a, b, eh, el; logic ed, bok, hok; int lat;
        d_op = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
        d_a  = '{32'hFFFF_FFF9, 32'h5, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        d_b  = '{32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1};
        for (int i = 0; i < 45; i++) begin
            if (i < 5) begin o = d_op[i]; a = d_a[i]; b = d_b[i]; end
            else begin o = 3'($urandom_range(2, 3)); a = rand_val(); b = rand_val(); end
            model(o, a, b, eh, el, ed);
            exec_op(o, a, b, 1'b0, lat, bok, hok);
            $display("[TB] div op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d", o, a, b, hi, lo, div_by_zero, lat);
            tests_run++; if (lat != W + 1) begin tests_failed++; $display("FAIL div_latency: got %0d expected %0d", lat, W + 1); end
            tests_run++; if (!(bok && hok)) begin tests_failed++; $display("FAIL div_busy_hold: got busy_ok=%b hold_ok=%b expected 1 1", bok, hok); end
            tests_run++;
            if ({hi, lo, div_by_zero, busy} !== {eh, el, ed, 1'b0}) begin
                tests_failed++;
                $display("FAIL div_result: got hi=%h lo=%h dbz=%b busy=%b expected hi=%h lo=%h dbz=%b busy=0",
                         hi, lo, div_by_zero, busy, eh, el, ed);
            end
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || div_by_zero !== 1'b0) begin
                tests_failed++; $display("FAIL div_done_pulse: got done=%b dbz=%b expected 0 0", done, div_by_zero);
            end
        end
    endtask

    task automatic test_move();
        logic [31:0] h0, l0, r;
        logic quiet;
        issue(OP_MTLO, 32'h5555_0000, 32'h0, 1'b0);
        l0 = lo;
        issue(OP_MTHI, 32'h0000_1234, 32'h0, 1'b0);
        $display("[TB] mthi 00001234 -> hi=%h lo=%h", hi, lo);
        tests_run++;
        if (hi !== 32'h0000_1234 || lo !== l0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b expected hi=00001234 lo=%h busy=0 done=0", hi, lo, busy, done, l0);
        end
        h0 = hi;
        issue(OP_MTLO, 32'hCAFE_F00D, 32'h0, 1'b1);
        $display("[TB] mtlo cafef00d -> hi=%h lo=%h", hi, lo);
        tests_run++;
        if (lo !== 32'hCAFE_F00D || hi !== h0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=cafef00d busy=0 done=0", hi, lo, busy, done, h0);
        end
        for (int o = 6; o <= 7; o++) begin
            h0 = hi; l0 = lo; r = $urandom;
            issue(3'(o), r, 32'h3, 1'b0);
            quiet = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0) quiet = 1'b0;
                @(posedge clk); #1;
            end
            $display("[TB] reserved op=%0d -> busy=%b hi=%h lo=%h", o, busy, hi, lo);
            tests_run++; if (!quiet) begin tests_failed++; $display("FAIL reserved_op: got state change for op %0d expected none", o); end
        end
    endtask

    task automatic test_start_ignored_and_cancel();
        int lat; logic bok, hok, seen;
        issue(OP_MULTU, 32'h3, 32'h4, 1'b0);
        lat = 0;
        for (int k = 1; k <= W + 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) lat = k;
            @(negedge clk);
            start = (k == 4); op = OP_DIVU; op_a = 32'h9; op_b = 32'h3;
        end
        start = 1'b0;
        $display("[TB] multu 3x4 with stray start -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        tests_run++;
        if (lat != W + 1 || hi !== 32'h0 || lo !== 32'hC) begin
            tests_failed++; $display("FAIL start_while_busy: got lat=%0d hi=%h lo=%h expected lat=33 hi=00000000 lo=0000000c", lat, hi, lo);
        end
        // Cancel during CALC, then cancel during FIN: neither may complete.
        for (int t = 0; t < 2; t++) begin
            issue(t == 0 ? OP_MULTU : OP_DIVU, 32'h64, 32'h7, 1'b0);
            seen = 1'b0;
            for (int k = 1; k <= W + 8; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) seen = 1'b1;
                @(negedge clk);
                cancel = (t == 0) ? (k == 9) : (k == W);
            end
            cancel = 1'b0;
            $display("[TB] cancel case %0d -> done_seen=%b busy=%b hi=%h lo=%h", t, seen, busy, hi, lo);
            tests_run++;
            if (seen !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'hC) begin
                tests_failed++;
                $display("FAIL cancel_%0d: got done_seen=%b busy=%b hi=%h lo=%h expected 0 0 00000000 0000000c", t, seen, busy, hi, lo);
            end
        end
        exec_op(OP_MULTU, 32'h6, 32'h7, 1'b1, lat, bok, hok);
        $display("[TB] start with cancel in idle -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        tests_run++;
        if (lat != W + 1 || hi !== 32'h0 || lo !== 32'd42) begin
            tests_failed++; $display("FAIL cancel_with_start: got lat=%0d hi=%h lo=%h expected lat=33 hi=00000000 lo=0000002a", lat, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] o; logic [31:0] a, b, eh, el; logic ed, bok, hok; int lat;
        for (int i = 0; i < 6; i++) begin
            o = 3'($urandom_range(0, 3)); a = rand_val(); b = rand_val();
            model(o, a, b, eh, el, ed);
            exec_op(o, a, b, 1'b0, lat, bok, hok);
            $display("[TB] b2b op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, a, b, hi, lo, lat);
            tests_run++;
            if (lat != W + 1 || {hi, lo, div_by_zero} !== {eh, el, ed}) begin
                tests_failed++;
                $display("FAIL back_to_back: got lat=%0d hi=%h lo=%h dbz=%b expected lat=33 hi=%h lo=%h dbz=%b",
                         lat, hi, lo, div_by_zero, eh, el, ed);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        issue(OP_MTHI, 32'hAAAA_5555, 32'h0, 1'b0);
        issue(OP_MTLO, 32'h1357_9BDF, 32'h0, 1'b0);
        issue(OP_DIV, $urandom, 32'h0000_0013, 1'b0);
        for (int k = 1; k <= 9; k++) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = OP_MULTU; cancel = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset mid-op -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b1; start = 1'b0; cancel = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL reset_no_done: got activity=1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_move();
        test_start_ignored_and_cancel();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
